// File: rtl/adat_frame_serializer.sv
// adat_frame_serializer
// Builds the 256-bit ADAT frame (sync, user bits, 48 data nibbles each
// followed by a 1 separator) from eight 24-bit samples plus four user bits,
// and shifts it out MSB first, one bit per bit-clock cycle. A single-entry
// holding buffer with a valid/ready handshake decouples the sample producer
// from frame timing.
//
// Ports:
//   clk_i          ADAT bit clock (256 x Fs)
//   rst_ni         synchronous active-low reset
//   sample_i       channel samples, channel 0 in [23:0], channel 7 in [191:168]
//   user_i         four user bits for the frame
//   valid_i        producer offers a frame's worth of data
//   ready_o        holding buffer empty; transfer on valid_i && ready_o
//   data_o         serial frame bit, to the NRZI encoder data input
//   output_en_o    line active, to the NRZI encoder output enable
//   frame_start_o  high while data_o carries bit 0 of a frame
//   underrun_o     pulse with frame_start_o when a frame starts without new data
//
// Configuration macro:
//   ADAT_FRAME_SERIALIZER_UNDERRUN_HOLD_EN  defined: repeat the last frame on
//   underrun; undefined: send zeroed samples and user bits on underrun.

module adat_frame_serializer #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
    input  logic [3:0]                   user_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         data_o,
    output logic                         output_en_o,
    output logic                         frame_start_o,
    output logic                         underrun_o
);

    localparam int unsigned DATA_W     = CHANNELS * SAMPLE_W;
    localparam int unsigned FRAME_W    = 256;
    localparam int unsigned NIBBLES    = DATA_W / 4;
    localparam int unsigned NIB_PER_CH = SAMPLE_W / 4;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;        // frame bit index currently on data_o
    logic [CNT_W-1:0]   cnt_nxt;
    logic [DATA_W-1:0]  smp_q;        // frame register: samples
    logic [3:0]         user_q;       // frame register: user bits
    logic [DATA_W-1:0]  buf_smp_q;    // holding buffer
    logic [3:0]         buf_user_q;
    logic [FRAME_W-1:0] frame_bits;   // frame_bits[k] is frame bit k

    assign cnt_nxt = cnt_q + CNT_W'(1);

    // Frame layout from the frame register; sync bits 0..9 stay zero.
    always_comb begin
        frame_bits     = '0;
        frame_bits[10] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_bits[11 + i] = user_q[3 - i];
        end
        frame_bits[15] = 1'b1;
        for (int n = 0; n < int'(NIBBLES); n++) begin
            for (int r = 0; r < 4; r++) begin
                frame_bits[16 + 5*n + r] =
                    smp_q[(n / int'(NIB_PER_CH)) * int'(SAMPLE_W)
                          + int'(SAMPLE_W) - 1 - 4 * (n % int'(NIB_PER_CH)) - r];
            end
            frame_bits[20 + 5*n] = 1'b1;
        end
    end

    // Sequencer, frame register, holding buffer and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            smp_q         <= '0;
            user_q        <= '0;
            buf_smp_q     <= '0;
            buf_user_q    <= '0;
            ready_o       <= 1'b1;
            data_o        <= 1'b0;
            output_en_o   <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // First transfer bypasses the buffer; bit 0 follows next cycle.
                    if (valid_i && ready_o) begin
                        smp_q         <= sample_i;
                        user_q        <= user_i;
                        state_q       <= RUN;
                        cnt_q         <= '0;
                        data_o        <= 1'b0;
                        output_en_o   <= 1'b1;
                        frame_start_o <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q  <= cnt_nxt;
                    // Bit 0 is sync, so the old frame's layout is safe at the wrap.
                    data_o <= frame_bits[cnt_nxt];
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        frame_start_o <= 1'b1;
                        if (!ready_o) begin
                            smp_q   <= buf_smp_q;
                            user_q  <= buf_user_q;
                            ready_o <= 1'b1;
                        end else if (valid_i) begin
                            smp_q   <= sample_i;
                            user_q  <= user_i;
                        end else begin
                            underrun_o <= 1'b1;
`ifndef ADAT_FRAME_SERIALIZER_UNDERRUN_HOLD_EN
                            smp_q      <= '0;
                            user_q     <= '0;
`endif
                        end
                    end else if (valid_i && ready_o) begin
                        buf_smp_q  <= sample_i;
                        buf_user_q <= user_i;
                        ready_o    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adat_frame_serializer.sv
// Scoreboard bench for adat_frame_serializer: a transaction-level model pushes
// each expected frame when it is loaded; a negedge monitor captures 256 bits
// after every frame_start_o and compares them with a frame built from the
// layout rules.
module tb_adat_frame_serializer;

    localparam int unsigned DW = 192;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic [3:0]    user_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o, data_o, output_en_o, frame_start_o, underrun_o;

    int checks = 0;
    int failures = 0;

    adat_frame_serializer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sample_i(sample_i), .user_i(user_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
        .output_en_o(output_en_o), .frame_start_o(frame_start_o),
        .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] s;
        logic [3:0]    u;
        bit            ur;
    } frame_t;

    frame_t exp_q[$];

    // Reference model state
    bit            m_run = 0;
    int            m_k = 0;
    bit            m_full = 0;
    bit            m_ready = 1;
    int            m_acc = 0;
    logic [DW-1:0] m_cur_s = '0, m_buf_s = '0;
    logic [3:0]    m_cur_u = '0, m_buf_u = '0;
    frame_t        m_f;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] exp_frame(input logic [DW-1:0] s, input logic [3:0] u);
        logic [255:0] f;
        int m, n;
        f = '0;
        for (int k = 0; k < 256; k++) begin
            if (k < 10)                  f[k] = 1'b0;
            else if (k == 10 || k == 15) f[k] = 1'b1;
            else if (k < 15)             f[k] = u[14 - k];
            else begin
                m = k - 16;
                n = m / 5;
                if (m % 5 == 4) f[k] = 1'b1;
                else            f[k] = s[(n / 6) * 24 + 23 - 4 * (n % 6) - (m % 5)];
            end
        end
        return f;
    endfunction

    task automatic push_frame(input bit ur);
        m_f.s = m_cur_s;
        m_f.u = m_cur_u;
        m_f.ur = ur;
        exp_q.push_back(m_f);
    endtask

    // Behavioural model: one frame every 256 cycles, one-deep buffer.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_run = 0; m_k = 0; m_full = 0;
            exp_q.delete();
        end else if (!m_run) begin
            if (valid_i) begin
                m_acc++;
                m_cur_s = sample_i; m_cur_u = user_i;
                push_frame(0);
                m_run = 1; m_k = 0;
            end
        end else if (m_k == 255) begin
            if (m_full) begin
                m_cur_s = m_buf_s; m_cur_u = m_buf_u; m_full = 0;
                push_frame(0);
            end else if (valid_i) begin
                m_acc++;
                m_cur_s = sample_i; m_cur_u = user_i;
                push_frame(0);
            end else begin
`ifndef ADAT_FRAME_SERIALIZER_UNDERRUN_HOLD_EN
                m_cur_s = '0; m_cur_u = '0;
`endif
                push_frame(1);
            end
            m_k = 0;
        end else begin
            if (valid_i && !m_full) begin
                m_acc++;
                m_buf_s = sample_i; m_buf_u = user_i; m_full = 1;
            end
            m_k++;
        end
        m_ready = !m_full;
    end

    // Monitor
    bit           mon_en = 0;
    bit           cap_on = 0;
    int           cap_idx = 0;
    logic [255:0] cap = '0;
    logic [255:0] first_cap = '0;
    int           frames_done = 0;
    frame_t       cur;

    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("ready", 256'(ready_o), 256'(m_ready));
            chk("output_en", 256'(output_en_o), 256'(m_run));
            chk("frame_start", 256'(frame_start_o), 256'(m_run && m_k == 0));
            if (!output_en_o) chk("data_idle", 256'(data_o), 256'(0));
            if (!frame_start_o) chk("underrun_stray", 256'(underrun_o), 256'(0));
            if (!output_en_o) cap_on = 0;
            else begin
                if (frame_start_o) begin
                    if (cap_on && cap_idx != 256) chk("frame_len", 256'(cap_idx), 256'(256));
                    if (exp_q.size() == 0) begin
                        chk("exp_queue_empty", 256'(1), 256'(0));
                        cap_on = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("underrun", 256'(underrun_o), 256'(cur.ur));
                        cap_on = 1;
                        cap_idx = 0;
                    end
                end
                if (cap_on && cap_idx < 256) begin
                    cap[cap_idx] = data_o;
                    cap_idx++;
                    if (cap_idx == 256) begin
                        chk("frame_bits", cap, exp_frame(cur.s, cur.u));
                        if (frames_done == 0) first_cap = cap;
                        frames_done++;
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand192();
        logic [DW-1:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] s, input logic [3:0] u, input bit keep);
        int c0, t;
        c0 = m_acc; t = 0;
        sample_i = s; user_i = u; valid_i = 1'b1;
        while (m_acc == c0 && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (m_acc == c0) chk("send_timeout", 256'(0), 256'(1));
        if (!keep) valid_i = 1'b0;
    endtask

    task automatic wait_k(input int target);
        int t;
        t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (!(m_run && m_k == target) && t < 1000);
        if (!(m_run && m_k == target)) chk("wait_k_timeout", 256'(target), 256'(-1));
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_done < n && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (frames_done < n) chk("frame_timeout", 256'(frames_done), 256'(n));
    endtask

    logic [DW-1:0] s;
    logic [24:0]   exp25;
    int            fd;

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_data", 256'(data_o), 256'(0));
        chk("rst_oe", 256'(output_en_o), 256'(0));
        chk("rst_fs", 256'(frame_start_o), 256'(0));
        chk("rst_ur", 256'(underrun_o), 256'(0));
        chk("rst_ready", 256'(ready_o), 256'(1));
        mon_en = 1;
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);

        // Directed first frame from IDLE
        s = '0;
        s[23:0] = 24'hABCDEF;
        send(s, 4'hA, 0);

        // One frame fed per frame period at a random point
        for (int i = 0; i < 5; i++) begin
            wait_k($urandom_range(1, 250));
            if (i == 0) begin
                for (int c = 0; c < 8; c++) s[c*24 +: 24] = 24'(24'h111111 * c);
                send(s, 4'h5, 0);
            end else begin
                send(rand192(), 4'($urandom), 0);
            end
            wait_k(0);
        end

        exp25 = '0;
        exp25[10] = 1'b1; exp25[11] = 1'b1; exp25[13] = 1'b1; exp25[15] = 1'b1;
        exp25[16] = 1'b1; exp25[18] = 1'b1; exp25[20] = 1'b1;
        exp25[21] = 1'b1; exp25[23] = 1'b1; exp25[24] = 1'b1;
        chk("first_frame_head", 256'(first_cap[24:0]), 256'(exp25));

        // Starve for two frames
        wait_k(0);
        wait_k(0);

        // Empty buffer, valid only in the k=255 cycle: bypass, no underrun
        wait_k(255);
        send(rand192(), 4'($urandom), 0);

        // Continuous valid: one accept per frame
        for (int i = 0; i < 4; i++) send(rand192(), 4'($urandom), 1);
        valid_i = 1'b0;

        // Reset mid-frame at k=100
        wait_k(100);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_oe", 256'(output_en_o), 256'(0));
        chk("midrst_data", 256'(data_o), 256'(0));
        chk("midrst_ready", 256'(ready_o), 256'(1));
        rst_ni = 1'b1;
        @(negedge clk_i);

        fd = frames_done;
        send(rand192(), 4'($urandom), 0);
        wait_k($urandom_range(1, 250));
        send(rand192(), 4'($urandom), 0);
        wait_frames(fd + 2);
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
